// File: rtl/sprite_fetch.sv
// sprite_fetch: fetches one pixel of a sprite stored packed in a word-wide SRAM.
// Define SPRITE_FETCH_CACHE_EN to add a single-word read cache in front of the SRAM.
module sprite_fetch #(
  parameter int SRAM_AW = 20,
  parameter int SRAM_DW = 16,
  parameter int PIXEL_W = 4,
  parameter int N_SPR = 8,
  parameter int SPR_W = 40,
  parameter int SPR_H = 40,
  parameter logic [SRAM_AW-1:0] SPR_BASE = 20'h4E200,
  parameter int RD_LAT = 2,
  parameter int ID_W = $clog2(N_SPR),
  parameter int X_W = $clog2(SPR_W),
  parameter int Y_W = $clog2(SPR_H)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [ID_W-1:0]    i_req_id,
  input  logic [X_W-1:0]     i_req_x,
  input  logic [Y_W-1:0]     i_req_y,
  output logic               o_sram_rd,
  output logic [SRAM_AW-1:0] o_sram_addr,
  input  logic [SRAM_DW-1:0] i_sram_data,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  output logic [PIXEL_W-1:0] o_pix,
  output logic               o_err
);
  localparam int PPW = SRAM_DW / PIXEL_W;
  localparam int REGION = SPR_W * SPR_H / PPW;
  localparam int SLOT_W = PPW > 1 ? $clog2(PPW) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q;
  logic [SRAM_AW-1:0] lin, addr_d, addr_q;
  logic [SLOT_W-1:0] slot_d, slot_q;
  logic [2:0] cnt_q;
  logic in_range, hit, fill;
  logic [PIXEL_W-1:0] hit_pix;
  assign lin = SRAM_AW'(i_req_y) * SRAM_AW'(SPR_W) + SRAM_AW'(i_req_x);
  assign addr_d = SPR_BASE + SRAM_AW'(i_req_id) * SRAM_AW'(REGION) + lin / SRAM_AW'(PPW);
  assign slot_d = SLOT_W'(lin % SRAM_AW'(PPW));
  assign in_range = 32'(i_req_id) < N_SPR && 32'(i_req_x) < SPR_W && 32'(i_req_y) < SPR_H;
  assign fill = state_q == WAIT && cnt_q == 3'(RD_LAT);
`ifdef SPRITE_FETCH_CACHE_EN
  logic [SRAM_AW-1:0] tag_q;
  logic [SRAM_DW-1:0] cdata_q;
  logic cvalid_q;
  assign hit = cvalid_q && tag_q == addr_d;
  assign hit_pix = cdata_q[slot_d*PIXEL_W +: PIXEL_W];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_q <= '0;
      cdata_q <= '0;
      cvalid_q <= 1'b0;
    end else if (fill) begin
      tag_q <= o_sram_addr;
      cdata_q <= i_sram_data;
      cvalid_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
  assign hit_pix = '0;
`endif
  // Short paths (hit, out of range) enter DONE with valid low and raise it one edge later
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      o_req_ready <= 1'b0;
      o_sram_rd <= 1'b0;
      o_sram_addr <= '0;
      o_pix_valid <= 1'b0;
      o_pix <= '0;
      o_err <= 1'b0;
      addr_q <= '0;
      slot_q <= '0;
      cnt_q <= '0;
    end else begin
      o_sram_rd <= 1'b0;
      case (state_q)
        IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            o_req_ready <= 1'b0;
            addr_q <= addr_d;
            slot_q <= slot_d;
            o_pix <= in_range ? hit_pix : '0;
            o_err <= !in_range;
            state_q <= (!in_range || hit) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          o_sram_rd <= 1'b1;
          o_sram_addr <= addr_q;
          cnt_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (fill) begin
            o_pix <= i_sram_data[slot_q*PIXEL_W +: PIXEL_W];
            o_err <= 1'b0;
            o_pix_valid <= 1'b1;
            state_q <= DONE;
          end else cnt_q <= cnt_q + 3'd1;
        end
        DONE: begin
          if (!o_pix_valid) o_pix_valid <= 1'b1;
          else if (i_pix_ready) begin
            o_pix_valid <= 1'b0;
            o_req_ready <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: directed bench for sprite_fetch with a fixed-latency SRAM responder.
module tb_sprite_fetch;
  logic clk = 0, rst = 1, req_valid = 0, req_ready, sram_rd, pix_valid, pix_ready = 0, err;
  logic [3:0] req_id = 0;
  logic [5:0] req_x = 0, req_y = 0;
  logic [19:0] sram_addr, last_addr = 0;
  logic [15:0] sram_data = 16'hBAD0, mem_word = 0;
  logic [3:0] pix;
  logic pipe1 = 0;
  int rd_cnt = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  sprite_fetch #(.ID_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_id(req_id), .i_req_x(req_x), .i_req_y(req_y),
    .o_sram_rd(sram_rd), .o_sram_addr(sram_addr), .i_sram_data(sram_data),
    .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_pix(pix), .o_err(err)
  );
  // SRAM returns mem_word exactly two cycles after the strobe cycle, garbage otherwise
  always @(posedge clk) begin
    pipe1 <= sram_rd;
    sram_data <= pipe1 ? mem_word : 16'hBAD0;
    if (sram_rd) begin
      rd_cnt <= rd_cnt + 1;
      last_addr <= sram_addr;
    end
  end
  task automatic do_req(input logic [3:0] id, input logic [5:0] x, input logic [5:0] y, output int lat);
    @(negedge clk);
    req_id = id;
    req_x = x;
    req_y = y;
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0;
    while (!pix_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic release_pix();
    @(negedge clk);
    pix_ready = 1;
    @(posedge clk);
    #1 pix_ready = 0;
    checks++;
    if (pix_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b, required valid=0 ready=1", pix_valid, req_ready);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, sram_rd, sram_addr, pix_valid, pix, err} !== 28'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b rd=%b addr=%h valid=%b pix=%h err=%b, required all 0",
               req_ready, sram_rd, sram_addr, pix_valid, pix, err);
    end
    rst = 0;
    @(posedge clk);
    #1 checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b, required 1", req_ready);
    end
  endtask
  task automatic test_miss();
    logic [3:0] ids[4] = '{4'd1, 4'd0, 4'd0, 4'd2};
    logic [5:0] xs[4] = '{6'd5, 6'd39, 6'd0, 6'd2};
    logic [5:0] ys[4] = '{6'd2, 6'd39, 6'd0, 6'd0};
    logic [15:0] words[4] = '{16'hA5C3, 16'h7000, 16'h1234, 16'h0F00};
    logic [19:0] addrs[4] = '{20'h4E3A5, 20'h4E38F, 20'h4E200, 20'h4E520};
    logic [3:0] pixs[4] = '{4'hC, 4'h7, 4'h4, 4'hF};
    int lat, n0;
    for (int i = 0; i < 4; i++) begin
      mem_word = words[i];
      n0 = rd_cnt;
      do_req(ids[i], xs[i], ys[i], lat);
      checks++;
      if (lat !== 4 || pix !== pixs[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL miss%0d: lat=%0d pix=%h err=%b, required lat=4 pix=%h err=0", i, lat, pix, err, pixs[i]);
      end
      checks++;
      if (rd_cnt - n0 !== 1 || last_addr !== addrs[i] || sram_addr !== addrs[i]) begin
        errors++;
        $display("FAIL miss%0d_addr: reads=%0d addr=%h held=%h, required reads=1 addr=%h",
                 i, rd_cnt - n0, last_addr, sram_addr, addrs[i]);
      end
      release_pix();
    end
  endtask
  task automatic test_out_of_range();
    logic [3:0] ids[4] = '{4'd8, 4'd0, 4'd0, 4'd15};
    logic [5:0] xs[4] = '{6'd0, 6'd40, 6'd0, 6'd63};
    logic [5:0] ys[4] = '{6'd0, 6'd0, 6'd40, 6'd63};
    int lat, n0;
    mem_word = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      n0 = rd_cnt;
      do_req(ids[i], xs[i], ys[i], lat);
      checks++;
      if (lat !== 1 || pix !== 4'h0 || err !== 1'b1 || rd_cnt !== n0) begin
        errors++;
        $display("FAIL oor%0d: lat=%0d pix=%h err=%b reads=%0d, required lat=1 pix=0 err=1 reads=0",
                 i, lat, pix, err, rd_cnt - n0);
      end
      release_pix();
    end
  endtask
  task automatic test_backpressure();
    int lat;
    mem_word = 16'h3C00;
    do_req(4'd5, 6'd10, 6'd10, lat);
    checks++;
    if (lat !== 4 || pix !== 4'hC || last_addr !== 20'h4EA36) begin
      errors++;
      $display("FAIL bp_fetch: lat=%0d pix=%h addr=%h, required lat=4 pix=c addr=4ea36", lat, pix, last_addr);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (pix_valid !== 1'b1 || pix !== 4'hC || err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b pix=%h err=%b ready=%b, required valid=1 pix=c err=0 ready=0",
                 i, pix_valid, pix, err, req_ready);
      end
    end
    release_pix();
  endtask
  task automatic test_reset_in_wait();
    int lat, n0;
    bit seen;
    mem_word = 16'hFFFF;
    @(negedge clk);
    req_id = 4'd3;
    req_x = 0;
    req_y = 0;
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1 checks++;
    if ({req_ready, sram_rd, sram_addr, pix_valid, pix, err} !== 28'h0) begin
      errors++;
      $display("FAIL rst_wait: ready=%b rd=%b addr=%h valid=%b pix=%h err=%b, required all 0",
               req_ready, sram_rd, sram_addr, pix_valid, pix, err);
    end
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (pix_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_late_data: valid_seen=%b ready=%b, required valid_seen=0 ready=1", seen, req_ready);
    end
    mem_word = 16'h3C00;
    n0 = rd_cnt;
    do_req(4'd5, 6'd10, 6'd10, lat);
    checks++;
    if (lat !== 4 || pix !== 4'hC || rd_cnt - n0 !== 1) begin
      errors++;
      $display("FAIL rst_refetch: lat=%0d pix=%h reads=%0d, required lat=4 pix=c reads=1", lat, pix, rd_cnt - n0);
    end
    release_pix();
  endtask
  task automatic test_back_to_back();
    int lat1, lat2, n0, exp_lat, exp_reads;
`ifdef SPRITE_FETCH_CACHE_EN
    exp_lat = 1;
    exp_reads = 1;
`else
    exp_lat = 4;
    exp_reads = 2;
`endif
    mem_word = 16'hA5C3;
    n0 = rd_cnt;
    do_req(4'd1, 6'd4, 6'd2, lat1);
    checks++;
    if (lat1 !== 4 || pix !== 4'h3 || last_addr !== 20'h4E3A5) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d pix=%h addr=%h, required lat=4 pix=3 addr=4e3a5", lat1, pix, last_addr);
    end
    release_pix();
    do_req(4'd1, 6'd6, 6'd2, lat2);
    checks++;
    if (lat2 !== exp_lat || pix !== 4'h5 || err !== 1'b0 || rd_cnt - n0 !== exp_reads) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d pix=%h err=%b reads=%0d, required lat=%0d pix=5 err=0 reads=%0d",
               lat2, pix, err, rd_cnt - n0, exp_lat, exp_reads);
    end
    release_pix();
  endtask
  initial begin
    test_reset();
    test_miss();
    test_out_of_range();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 Parameter SRAM_AW, default 20: SRAM address width.
REQ-002 Parameter SRAM_DW, default 16: SRAM data width.
REQ-003 Parameter PIXEL_W, default 4: bits per pixel; PPW = SRAM_DW/PIXEL_W pixels per word; SRAM_DW SHALL be an integer multiple of PIXEL_W.
REQ-004 Parameter N_SPR, default 8: sprite regions, contiguous, equal size.
REQ-005 Parameter SPR_W / SPR_H, default 40 / 40: sprite dimensions in pixels; SPR_W*SPR_H SHALL be a multiple of PPW.
REQ-006 Parameter SPR_BASE, default 20'h4E200: word address of sprite 0; REGION = SPR_W*SPR_H/PPW words per sprite.
REQ-007 Parameter RD_LAT, default 2, range 1..7: cycles from o_sram_rd to valid i_sram_data.
REQ-008 i_clk  in  1  sole clock, rising edge.
REQ-009 i_rst  in  1  asynchronous, active-high reset.
REQ-010 i_req_valid / o_req_ready  in/out  1/1  request handshake.
REQ-011 i_req_id  in  $clog2(N_SPR)  sprite index.
REQ-012 i_req_x / i_req_y  in  $clog2(SPR_W) / $clog2(SPR_H)  pixel coordinate inside sprite.
REQ-013 o_sram_rd  out  1  one-cycle read strobe; o_sram_addr  out  SRAM_AW  word address.
REQ-014 i_sram_data  in  SRAM_DW  read data.
REQ-015 o_pix_valid / i_pix_ready  out/in  1/1  result handshake; o_pix  out  PIXEL_W  pixel; o_err  out  1  request out of range.

Function
REQ-016 States: IDLE, ISSUE, WAIT, DONE; o_req_ready SHALL be 1 only in IDLE.
REQ-017 Request accepted on a clock edge with i_req_valid && o_req_ready; id, x, y registered at that edge.
REQ-018 lin = y*SPR_W + x; addr = SPR_BASE + id*REGION + lin/PPW, computed at full SRAM_AW width, unsigned; slot = lin % PPW.
REQ-019 IDLE→ISSUE on accept; ISSUE drives o_sram_rd=1 and o_sram_addr=addr for exactly one cycle, then →WAIT.
REQ-020 WAIT counts RD_LAT cycles after the strobe cycle, samples i_sram_data on the last, →DONE.
REQ-021 o_pix = word[slot*PIXEL_W +: PIXEL_W] (slot 0 = least-significant bits).
REQ-022 DONE holds o_pix_valid=1 with stable o_pix/o_err until i_pix_ready=1; transfer edge →IDLE; a new request is accepted no earlier than the following cycle.
REQ-023 Miss latency: accept edge to o_pix_valid rising = RD_LAT+2 cycles.
REQ-024 id >= N_SPR, x >= SPR_W or y >= SPR_H: no SRAM access, IDLE→DONE with o_pix=0, o_err=1.
REQ-025 o_sram_addr SHALL hold its last value when o_sram_rd=0.

Reset
REQ-026 On i_rst=1 (any state, any cycle): state=IDLE, o_sram_rd=0, o_sram_addr=0, o_pix_valid=0, o_pix=0, o_err=0, cache invalid; a read in flight is discarded, its late data ignored.
REQ-027 o_req_ready SHALL be 0 while i_rst=1 and 1 from the first edge after deassertion.

Configuration
REQ-028 Macro SPRITE_FETCH_CACHE_EN defined: single-word cache (tag = addr, data = word, valid bit); an in-range request whose addr equals a valid tag goes IDLE→DONE without o_sram_rd, latency 1 cycle; every SRAM fill updates the tag and sets valid.
REQ-029 SPRITE_FETCH_CACHE_EN undefined: no cache storage; every in-range request performs an SRAM read per REQ-019..023.

Verification
REQ-030 Defaults, id=1, x=5, y=2 → single o_sram_rd with addr 20'h4E3A5, slot 1; i_sram_data=16'hA5C3 → o_pix=4'hC, o_err=0, valid 4 cycles after accept.
REQ-031 id=0, x=39, y=39 → addr 20'h4E38F, slot 3; data 16'h7000 → o_pix=4'h7.
REQ-032 id=8 (N_SPR=8 with a wider id port in the bench) or x=40 → no o_sram_rd, o_pix=0, o_err=1 after 1 cycle.
REQ-033 i_pix_ready held 0 for 10 cycles in DONE → o_pix_valid, o_pix stable, o_req_ready=0 throughout; ready=1 → IDLE next edge.
REQ-034 i_rst pulsed during WAIT → outputs at reset values immediately, no o_pix_valid from the aborted read, next request behaves as a miss.
REQ-035 With SPRITE_FETCH_CACHE_EN: id=1, x=4 then x=6 at y=2 → one SRAM read total, second result 1 cycle after accept; without the macro → two reads.
